// File: rtl/orr_pkg.sv
// Shared types and constants for the OEM raster reader.
// Bank index constants are bit positions in rd_en: {even4..even1, odd4..odd1}.
package orr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } orr_state_e;

  localparam int NPIX    = 256;
  localparam int BANK_AW = 5;

  localparam logic [2:0] ODD1  = 3'd0;
  localparam logic [2:0] ODD2  = 3'd1;
  localparam logic [2:0] ODD3  = 3'd2;
  localparam logic [2:0] ODD4  = 3'd3;
  localparam logic [2:0] EVEN1 = 3'd4;
  localparam logic [2:0] EVEN2 = 3'd5;
  localparam logic [2:0] EVEN3 = 3'd6;
  localparam logic [2:0] EVEN4 = 3'd7;

  // One in-flight read: which pixel it belongs to and which bank answers it.
  typedef struct packed {
    logic       vld;
    logic [7:0] idx;
    logic [2:0] sel;
  } orr_ret_t;

  // Bank index for pixel n: quadrant group in the low bits, checkerboard parity on top.
  function automatic logic [2:0] bank_sel_of(input logic [7:0] n);
    return {n[4] ^ n[0], n[7:6]};
  endfunction

  // One-hot bank enable for pixel n.
  function automatic logic [7:0] bank_of(input logic [7:0] n);
    return 8'h01 << bank_sel_of(n);
  endfunction

endpackage

// File: rtl/orr_skid_fifo.sv
// Small synchronous FIFO absorbing read returns while the pixel sink stalls.
// Push and pop in the same cycle are allowed; a push into a full FIFO is a design error.
module orr_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // The upstream credit scheme must never push into a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/oem_raster_reader.sv
// Reads the eight checkerboard/quadrant banks back in raster order after the
// writer finishes and streams the 16x16 frame on a valid/ready interface.
// Optional feature macro: ORR_CHECKSUM_EN adds frame_sum/frame_sum_vld.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for a rising edge of oem_finish
//  READ  | issuing one bank read per cycle while credits remain
//  DRAIN | all 256 reads issued; waiting for returns and FIFO to empty
//  DONE  | one-cycle frame_done pulse, then back to IDLE
module oem_raster_reader
  import orr_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               oem_finish,
  output logic [BANK_AW-1:0] rd_addr,
  output logic [7:0]         rd_en,
  input  logic [7:0]         odd1_q,
  input  logic [7:0]         odd2_q,
  input  logic [7:0]         odd3_q,
  input  logic [7:0]         odd4_q,
  input  logic [7:0]         even1_q,
  input  logic [7:0]         even2_q,
  input  logic [7:0]         even3_q,
  input  logic [7:0]         even4_q,
  output logic [7:0]         pix_data,
  output logic [7:0]         pix_idx,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               frame_done,
  output logic               busy
`ifdef ORR_CHECKSUM_EN
  ,
  output logic [15:0]        frame_sum,
  output logic               frame_sum_vld
`endif
);

  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [CW:0] CREDITS  = (CW + 1)'(FIFO_D);
  localparam logic [7:0]  LAST_PIX = 8'(NPIX - 1);

  orr_state_e         state_q, state_d;
  logic               fin_q, fin_d;
  logic [7:0]         n_q, n_d;
  logic [CW-1:0]      infl_q, infl_d;
  logic [BANK_AW-1:0] rd_addr_q, rd_addr_d;
  orr_ret_t           ret_q [RD_LAT];
  orr_ret_t           ret_d [RD_LAT];

  logic               start;
  logic               issue;
  logic               credit_ok;
  logic               ret_push;
  logic [7:0]         ret_data;
  logic [16:0]        fifo_wdata;
  logic [16:0]        fifo_rdata;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic               pop;

  // FSM next-state, read issue and status outputs.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    issue      = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    fin_d      = oem_finish;
    start      = (state_q == IDLE) & oem_finish & ~fin_q;
    // Pops in the current cycle are not counted, so credits stay conservative.
    credit_ok  = ({1'b0, infl_q} + {1'b0, fifo_cnt}) < CREDITS;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          n_d     = '0;
        end
      end
      READ: begin
        busy = 1'b1;
        if (credit_ok) begin
          issue = 1'b1;
          n_d   = n_q + 8'd1;
          if (n_q == LAST_PIX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (infl_q == '0 && fifo_empty) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rd_en     = issue ? bank_of(n_q) : 8'h00;
    rd_addr   = issue ? n_q[5:1] : rd_addr_q;
    rd_addr_d = rd_addr;
  end

  // Return pipeline tracking in-flight reads, bank data mux and in-flight count.
  always_comb begin
    ret_d[0].vld = issue;
    ret_d[0].idx = n_q;
    ret_d[0].sel = bank_sel_of(n_q);
    for (int i = 1; i < RD_LAT; i++) ret_d[i] = ret_q[i-1];
    ret_push = ret_q[RD_LAT-1].vld;
    case (ret_q[RD_LAT-1].sel)
      ODD1:    ret_data = odd1_q;
      ODD2:    ret_data = odd2_q;
      ODD3:    ret_data = odd3_q;
      ODD4:    ret_data = odd4_q;
      EVEN1:   ret_data = even1_q;
      EVEN2:   ret_data = even2_q;
      EVEN3:   ret_data = even3_q;
      default: ret_data = even4_q;
    endcase
    fifo_wdata = {ret_data, ret_q[RD_LAT-1].idx, ret_q[RD_LAT-1].idx == LAST_PIX};
    case ({issue, ret_push})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      fin_q     <= 1'b0;
      n_q       <= '0;
      infl_q    <= '0;
      rd_addr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) ret_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      fin_q     <= fin_d;
      n_q       <= n_d;
      infl_q    <= infl_d;
      rd_addr_q <= rd_addr_d;
      ret_q     <= ret_d;
    end
  end

  orr_skid_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (17)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (ret_push),
    .push_data (fifo_wdata),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = fifo_rdata[16:9];
  assign pix_idx   = fifo_rdata[8:1];
  assign pix_last  = fifo_rdata[0] & ~fifo_empty;
  assign pop       = pix_valid & pix_ready;

`ifdef ORR_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  // Running sum of accepted pixels, cleared when a frame starts.
  always_comb begin
    sum_d = sum_q;
    if (start)    sum_d = '0;
    else if (pop) sum_d = sum_q + {8'h00, pix_data};
  end

  // Checksum register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign frame_sum     = sum_q;
  assign frame_sum_vld = frame_done;
`endif

endmodule

// File: tb/tb_oem_raster_reader.sv
// Self-checking bench for oem_raster_reader: bank models, a raster-order
// reference stream, mapping vectors and reset/restart sequences.
module tb_oem_raster_reader;

  localparam int RD_LAT = 1;
  localparam int FIFO_D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       oem_finish;
  logic [4:0] rd_addr;
  logic [7:0] rd_en;
  logic [7:0] pix_data, pix_idx;
  logic       pix_valid, pix_ready, pix_last, frame_done, busy;
`ifdef ORR_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic        frame_sum_vld;
`endif

  logic [7:0] mem [8][32];
  logic [7:0] q1 [8];
  logic [7:0] q2 [8];
  logic [7:0] bq [8];

  int         issue_total = 0;
  logic [7:0] iss_en   [4096];
  logic [4:0] iss_addr [4096];

  int n_pass  = 0;
  int n_total = 0;
  bit all_ff  = 1'b0;
  int last_sum = 0;

  always #5 clk = ~clk;

  oem_raster_reader #(.RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .oem_finish (oem_finish),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .odd1_q     (bq[0]),
    .odd2_q     (bq[1]),
    .odd3_q     (bq[2]),
    .odd4_q     (bq[3]),
    .even1_q    (bq[4]),
    .even2_q    (bq[5]),
    .even3_q    (bq[6]),
    .even4_q    (bq[7]),
    .pix_data   (pix_data),
    .pix_idx    (pix_idx),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef ORR_CHECKSUM_EN
    ,
    .frame_sum     (frame_sum),
    .frame_sum_vld (frame_sum_vld)
`endif
  );

  // Bank memories with registered read, extra stage when RD_LAT is 2.
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (rd_en[b]) q1[b] <= mem[b][rd_addr];
      q2[b] <= q1[b];
    end
  end

  always_comb begin
    for (int b = 0; b < 8; b++) bq[b] = (RD_LAT == 1) ? q1[b] : q2[b];
  end

  // Log every issued read.
  always @(posedge clk) begin
    if (rd_en != 8'h00) begin
      if (issue_total < 4096) begin
        iss_en[issue_total]   <= rd_en;
        iss_addr[issue_total] <= rd_addr;
      end
      issue_total <= issue_total + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference mapping from raster index to bank/address.
  function automatic int ref_bank(input int n);
    int r, c;
    r = n / 16;
    c = n % 16;
    return (((r + c) % 2) ? 4 : 0) + n / 64;
  endfunction

  function automatic int ref_addr(input int n);
    return (n % 64) / 2;
  endfunction

  function automatic logic [7:0] exp_data(input int n);
    logic [7:0] v;
    v = 8'(n) ^ 8'hA5;
    return all_ff ? 8'hFF : v;
  endfunction

  task automatic load_mem();
    for (int n = 0; n < 256; n++) mem[ref_bank(n)][ref_addr(n)] = exp_data(n);
  endtask

  // mode 0: ready held high; 1: random ready (30% low) with fin toggle; 2: ready low 100 cycles.
  task automatic run_frame(input int mode, output int base);
    int nexp, first_i, last_i, done_i, done_cnt, last_cnt;
    int ord_err, stall_err, out_err, busy_err, map_err, sum_exp, act_sum;
    logic pv_prev, pr_prev;
    logic [7:0] pd_prev, pi_prev;
    base = issue_total;
    nexp = 0; first_i = -1; last_i = -1; done_i = -1; done_cnt = 0; last_cnt = 0;
    ord_err = 0; stall_err = 0; out_err = 0; busy_err = 0; map_err = 0;
    sum_exp = 0; act_sum = -1;
    pv_prev = 1'b0; pr_prev = 1'b0; pd_prev = '0; pi_prev = '0;
    @(negedge clk);
    oem_finish = 1'b1;
    pix_ready  = (mode != 2);
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (pix_valid && first_i < 0) first_i = i;
      if (pv_prev && !pr_prev && (!pix_valid || pix_data !== pd_prev || pix_idx !== pi_prev))
        stall_err++;
      if (issue_total - base - nexp > FIFO_D) out_err++;
      if (frame_done) begin
        done_cnt++;
        if (done_i < 0) done_i = i;
`ifdef ORR_CHECKSUM_EN
        act_sum = frame_sum_vld ? int'(frame_sum) : -2;
`endif
      end
      if ((done_i < 0 && !busy) || (frame_done && busy) || (done_i > 0 && i > done_i && busy))
        busy_err++;
      if (mode == 2 && i == 101) chk("reads_while_stalled", issue_total - base, FIFO_D);
      if (mode == 1 && i == 50) oem_finish = 1'b0;
      if (mode == 1 && i == 60) oem_finish = 1'b1;
      case (mode)
        1:       pix_ready = ($urandom_range(99) >= 30);
        2:       pix_ready = (i > 100);
        default: pix_ready = 1'b1;
      endcase
      #1;
      if (pix_valid && pix_ready) begin
        if (nexp > 255 || pix_idx !== 8'(nexp) || pix_data !== exp_data(nexp) ||
            pix_last !== (nexp == 255))
          ord_err++;
        if (pix_last) last_cnt++;
        sum_exp = (sum_exp + int'(pix_data)) % 65536;
        nexp++;
        last_i = i;
      end
      pv_prev = pix_valid; pr_prev = pix_ready; pd_prev = pix_data; pi_prev = pix_idx;
      if (done_i > 0 && i > done_i + 3) break;
    end
    for (int k = 0; k < 256; k++) begin
      if (base + k < 4096) begin
        if (iss_en[base+k] !== (8'h01 << ref_bank(k)) || iss_addr[base+k] !== 5'(ref_addr(k)))
          map_err++;
      end
    end
    chk($sformatf("m%0d_first_valid_lat", mode), first_i - 1, RD_LAT + 1);
    chk($sformatf("m%0d_pixels", mode), nexp, 256);
    chk($sformatf("m%0d_order_errs", mode), ord_err, 0);
    chk($sformatf("m%0d_stall_errs", mode), stall_err, 0);
    chk($sformatf("m%0d_outstanding_errs", mode), out_err, 0);
    chk($sformatf("m%0d_busy_errs", mode), busy_err, 0);
    chk($sformatf("m%0d_last_count", mode), last_cnt, 1);
    chk($sformatf("m%0d_done_pulses", mode), done_cnt, 1);
    chk($sformatf("m%0d_done_after_last", mode), done_i - last_i, 2);
    chk($sformatf("m%0d_issues", mode), issue_total - base, 256);
    chk($sformatf("m%0d_map_errs", mode), map_err, 0);
    if (mode == 0) chk("m0_done_cycle", done_i - 1, 258 + RD_LAT);
`ifdef ORR_CHECKSUM_EN
    chk($sformatf("m%0d_frame_sum", mode), act_sum, sum_exp);
    last_sum = act_sum;
`endif
  endtask

  task automatic idle_check(input string name, input int cycles);
    int s, berr;
    s = issue_total;
    berr = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (busy || frame_done || pix_valid) berr++;
    end
    chk({name, "_issues"}, issue_total - s, 0);
    chk({name, "_busy"}, berr, 0);
  endtask

  task automatic drop_fin();
    @(negedge clk);
    oem_finish = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int         n;
    logic [7:0] en;
    logic [4:0] addr;
  } map_vec_t;

  initial begin
    map_vec_t mv [8];
    int base0, bdummy, found;

    mv[0] = '{n: 0,   en: 8'h01, addr: 5'd0};
    mv[1] = '{n: 1,   en: 8'h10, addr: 5'd0};
    mv[2] = '{n: 16,  en: 8'h10, addr: 5'd8};
    mv[3] = '{n: 17,  en: 8'h01, addr: 5'd8};
    mv[4] = '{n: 255, en: 8'h08, addr: 5'd31};
    mv[5] = '{n: 64,  en: 8'h02, addr: 5'd0};
    mv[6] = '{n: 130, en: 8'h04, addr: 5'd1};
    mv[7] = '{n: 193, en: 8'h80, addr: 5'd0};

    reset_n = 1'b0;
    oem_finish = 1'b0;
    pix_ready = 1'b0;
    load_mem();
    repeat (3) @(negedge clk);
    chk("rst_flags", {pix_valid, pix_last, frame_done, busy}, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_pix", {pix_data, pix_idx}, 0);
`ifdef ORR_CHECKSUM_EN
    chk("rst_sum", {frame_sum_vld, frame_sum}, 0);
`endif
    reset_n = 1'b1;
    idle_check("idle_no_fin", 3);

    run_frame(0, base0);
    for (int v = 0; v < 8; v++) begin
      chk($sformatf("map_en_n%0d", mv[v].n), iss_en[base0 + mv[v].n], mv[v].en);
      chk($sformatf("map_addr_n%0d", mv[v].n), iss_addr[base0 + mv[v].n], mv[v].addr);
    end
    idle_check("fin_held", 30);
    drop_fin();

    run_frame(1, bdummy);
    idle_check("no_queued_frame", 20);
    drop_fin();

    run_frame(2, bdummy);
    drop_fin();

    // Reset in the middle of a frame.
    @(negedge clk);
    oem_finish = 1'b1;
    pix_ready  = 1'b1;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pix_valid && pix_idx == 8'd100) begin
        found = 1;
        break;
      end
    end
    chk("reached_n100", found, 1);
    reset_n = 1'b0;
    oem_finish = 1'b0;
    #1;
    chk("midrst_flags", {pix_valid, pix_last, frame_done, busy}, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_pix", {pix_data, pix_idx}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_check("after_reset", 10);

    run_frame(0, bdummy);
    drop_fin();

`ifdef ORR_CHECKSUM_EN
    all_ff = 1'b1;
    load_mem();
    run_frame(0, bdummy);
    chk("sum_all_ff", last_sum, 32'hFF00);
    drop_fin();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
